// File: rtl/edge_stream_sequencer_if.sv
// Signal bundle between edge_stream_sequencer (master) and its host/detector side (slave).
// resultSum is present only when EDGE_SEQ_CHECKSUM_EN is defined.
interface edge_stream_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              wrEn;
  logic [DATA_W-1:0] wrData;
  logic              start;
  logic              frameLoaded;
  logic              busy;
  logic [DATA_W-1:0] lRArray;
  logic [DATA_W-1:0] uDArray;
  logic              enb;
  logic              buffLRMode;
  logic              buffUDMode;
  logic              resetBuff;
  logic              complete;
  logic [DATA_W-1:0] detData;
  logic              outValid;
  logic [DATA_W-1:0] outData;
  logic              done;
  logic              timeout;
`ifdef EDGE_SEQ_CHECKSUM_EN
  logic [15:0]       resultSum;
`endif

  modport master (
    input  wrEn, wrData, start, complete, detData,
    output frameLoaded, busy, lRArray, uDArray, enb, buffLRMode, buffUDMode,
           resetBuff, outValid, outData, done, timeout
`ifdef EDGE_SEQ_CHECKSUM_EN
    , output resultSum
`endif
  );

  modport slave (
    output wrEn, wrData, start, complete, detData,
    input  frameLoaded, busy, lRArray, uDArray, enb, buffLRMode, buffUDMode,
           resetBuff, outValid, outData, done, timeout
`ifdef EDGE_SEQ_CHECKSUM_EN
    , input resultSum
`endif
  );
endinterface

// File: rtl/edge_stream_sequencer.sv
// Buffers one raster frame, replays it row-major and column-major to the edge detector,
// then drains and forwards results. Optional result checksum: EDGE_SEQ_CHECKSUM_EN.
module edge_stream_sequencer #(
  parameter int IMG_W     = 4,
  parameter int IMG_H     = 4,
  parameter int DATA_W    = 8,
  parameter int DRAIN_MAX = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  edge_stream_sequencer_if.master  bus
);
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int ADDR_W = $clog2(NPIX);
  localparam int PTR_W  = $clog2(NPIX + 1);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int COL_W  = $clog2(IMG_W);
  localparam int DCNT_W = $clog2(DRAIN_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_GAP, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   frame_mem [NPIX];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic                frame_loaded_q, frame_loaded_d;
  logic [ADDR_W-1:0]   lr_addr_q, lr_addr_d;
  logic [ADDR_W-1:0]   ud_addr_q, ud_addr_d;
  logic [ROW_W-1:0]    ud_row_q, ud_row_d;
  logic [COL_W-1:0]    ud_col_q, ud_col_d;
  logic [DCNT_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic                enb_q, enb_d;
  logic                buff_mode_q, buff_mode_d;
  logic                reset_buff_q, reset_buff_d;
  logic                busy_q, busy_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic [DATA_W-1:0]   lr_data_q, ud_data_q;
  logic                wr_accept, start_accept;

  assign wr_accept    = (state_q == S_IDLE) && !frame_loaded_q && bus.wrEn;
  assign start_accept = (state_q == S_IDLE) && frame_loaded_q && bus.start;

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    frame_loaded_d = frame_loaded_q;
    lr_addr_d      = lr_addr_q;
    ud_addr_d      = ud_addr_q;
    ud_row_d       = ud_row_q;
    ud_col_d       = ud_col_q;
    drain_cnt_d    = drain_cnt_q;
    out_valid_d    = 1'b0;
    out_data_d     = out_data_q;
    timeout_d      = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (wr_accept) begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (wr_ptr_q == PTR_W'(NPIX - 1)) frame_loaded_d = 1'b1;
        end
        if (start_accept) begin
          state_d   = S_CLEAR;
          timeout_d = 1'b0;
        end
      end
      S_CLEAR: begin
        state_d   = S_STREAM;
        lr_addr_d = '0;
        ud_addr_d = '0;
        ud_row_d  = '0;
        ud_col_d  = '0;
      end
      S_STREAM: begin
        if (lr_addr_q == ADDR_W'(NPIX - 1)) begin
          state_d = S_GAP;
        end else begin
          lr_addr_d = lr_addr_q + ADDR_W'(1);
          // Column-major walk: step down a row, or restart at the top of the next column.
          if (ud_row_q == ROW_W'(IMG_H - 1)) begin
            ud_row_d  = '0;
            ud_col_d  = ud_col_q + COL_W'(1);
            ud_addr_d = ADDR_W'(ud_col_q) + ADDR_W'(1);
          end else begin
            ud_row_d  = ud_row_q + ROW_W'(1);
            ud_addr_d = ud_addr_q + ADDR_W'(IMG_W);
          end
        end
      end
      S_GAP: begin
        state_d     = S_DRAIN;
        drain_cnt_d = '0;
      end
      S_DRAIN: begin
        // complete takes priority over the drain limit in the same cycle.
        if (bus.complete) begin
          state_d = S_DONE;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = bus.detData;
          if (drain_cnt_q == DCNT_W'(DRAIN_MAX - 1)) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end else begin
            drain_cnt_d = drain_cnt_q + DCNT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d        = S_IDLE;
        frame_loaded_d = 1'b0;
        wr_ptr_d       = '0;
      end
      default: state_d = S_IDLE;
    endcase
    enb_d        = (state_d == S_STREAM) || (state_d == S_DRAIN);
    buff_mode_d  = (state_d == S_DRAIN);
    reset_buff_d = (state_d == S_CLEAR);
    done_d       = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      frame_loaded_q <= 1'b0;
      lr_addr_q      <= '0;
      ud_addr_q      <= '0;
      ud_row_q       <= '0;
      ud_col_q       <= '0;
      drain_cnt_q    <= '0;
      enb_q          <= 1'b0;
      buff_mode_q    <= 1'b0;
      reset_buff_q   <= 1'b0;
      busy_q         <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      frame_loaded_q <= frame_loaded_d;
      lr_addr_q      <= lr_addr_d;
      ud_addr_q      <= ud_addr_d;
      ud_row_q       <= ud_row_d;
      ud_col_q       <= ud_col_d;
      drain_cnt_q    <= drain_cnt_d;
      enb_q          <= enb_d;
      buff_mode_q    <= buff_mode_d;
      reset_buff_q   <= reset_buff_d;
      busy_q         <= busy_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      done_q         <= done_d;
      timeout_q      <= timeout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) frame_mem[wr_ptr_q[ADDR_W-1:0]] <= bus.wrData;
  end

  // Registered reads present pixel k in the same cycle enb first shows 1; GAP holds them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lr_data_q <= '0;
      ud_data_q <= '0;
    end else if (state_d == S_STREAM) begin
      lr_data_q <= frame_mem[lr_addr_d];
      ud_data_q <= frame_mem[ud_addr_d];
    end
  end

`ifdef EDGE_SEQ_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (state_d == S_CLEAR) sum_d = '0;
    else if (out_valid_d)   sum_d = sum_q + 16'(out_data_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sum_q <= '0;
    else        sum_q <= sum_d;
  end

  assign bus.resultSum = sum_q;
`endif

  assign bus.frameLoaded = frame_loaded_q;
  assign bus.busy        = busy_q;
  assign bus.lRArray     = lr_data_q;
  assign bus.uDArray     = ud_data_q;
  assign bus.enb         = enb_q;
  assign bus.buffLRMode  = buff_mode_q;
  assign bus.buffUDMode  = buff_mode_q;
  assign bus.resetBuff   = reset_buff_q;
  assign bus.outValid    = out_valid_q;
  assign bus.outData     = out_data_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_edge_stream_sequencer.sv
// Scoreboard bench for edge_stream_sequencer: stimulus pushes expectations, a monitor
// pops and compares; includes a behavioural detector model for the drain phase.
module tb_edge_stream_sequencer;
  localparam int W = 4, H = 4, DW = 8, DMAX = 8, N = W * H;

  typedef struct {
    int beats;
    bit to;
  } frame_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;

  logic [DW-1:0] pix [N];
  logic [DW-1:0] exp_lr[$];
  logic [DW-1:0] exp_ud[$];
  logic [DW-1:0] exp_res[$];
  frame_t        exp_frm[$];
  int            det_r = 0;
  int            det_mode = 0;

  edge_stream_sequencer_if #(.DATA_W(DW)) bus();

  edge_stream_sequencer #(
    .IMG_W(W), .IMG_H(H), .DATA_W(DW), .DRAIN_MAX(DMAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_pix(input int from, input int to);
    for (int k = from; k < to; k++) begin
      @(negedge clk);
      bus.wrEn   = 1'b1;
      bus.wrData = pix[k];
    end
    @(negedge clk);
    bus.wrEn = 1'b0;
  endtask

  task automatic load_frame(input int mode);
    for (int k = 0; k < N; k++) pix[k] = (mode == 1) ? DW'(k) : DW'($urandom);
    write_pix(0, N - 1);
    check("loaded_early", bus.frameLoaded, 1'b0);
    write_pix(N - 1, N);
    check("frame_loaded", bus.frameLoaded, 1'b1);
    $display("load: %0d pixels, mode %0d", N, mode);
  endtask

  // Expected streams come straight from the raster/column-major definitions.
  task automatic issue_frame(input int r, input int mode);
    frame_t f;
    det_r    = r;
    det_mode = mode;
    for (int k = 0; k < N; k++) begin
      exp_lr.push_back(pix[k]);
      exp_ud.push_back(pix[(k % H) * W + k / H]);
    end
    f.beats = (r >= DMAX) ? DMAX : r;
    f.to    = (r >= DMAX);
    exp_frm.push_back(f);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.wrEn   = 1'b1;
    bus.wrData = 8'h5A;
    @(negedge clk);
    bus.start = 1'b0;
    bus.wrEn  = 1'b0;
    check("busy_after_start", bus.busy, 1'b1);
    check("timeout_cleared", bus.timeout, 1'b0);
  endtask

  task automatic wait_done();
    bit seen = 0;
    int cyc = 0;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      if (bus.done) seen = 1;
      cyc++;
    end
    check("done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("idle_busy", bus.busy, 1'b0);
    check("frame_released", bus.frameLoaded, 1'b0);
  endtask

  task automatic run_frame(input int r, input int mode);
    issue_frame(r, mode);
    wait_done();
    $display("frame: results=%0d mode=%0d timeout=%0b", r, mode, bus.timeout);
  endtask

  // Detector model: answers each drain cycle, raising complete after det_r results.
  initial begin
    int n;
    logic [DW-1:0] d;
    n = 0;
    bus.complete = 1'b0;
    bus.detData  = '0;
    forever begin
      @(negedge clk);
      if (reset && bus.buffLRMode) begin
        if (n >= det_r) begin
          bus.complete = 1'b1;
        end else begin
          case (det_mode)
            1:       d = 8'hA0 + DW'(n);
            2:       d = 8'hFF;
            default: d = DW'($urandom);
          endcase
          bus.detData  = d;
          bus.complete = 1'b0;
          exp_res.push_back(d);
        end
        n++;
      end else begin
        bus.complete = 1'b0;
        n = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a stream beat, result or done.
  initial begin
    int stream_cnt;
    int beat_cnt;
    logic prev_rb;
    frame_t f;
    stream_cnt = 0;
    beat_cnt   = 0;
    prev_rb    = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stream_cnt = 0;
        beat_cnt   = 0;
        prev_rb    = 1'b0;
      end else begin
        if (bus.resetBuff) begin
          check("clear_enb", bus.enb, 1'b0);
          stream_cnt = 0;
          beat_cnt   = 0;
        end
        if (bus.enb && !bus.buffLRMode) begin
          if (stream_cnt == 0) check("clear_before_stream", prev_rb, 1'b1);
          if (exp_lr.size() == 0) begin
            check("stream_unexpected", 32'(stream_cnt), 32'hFFFF_FFFF);
          end else begin
            check("lRArray", bus.lRArray, exp_lr.pop_front());
            check("uDArray", bus.uDArray, exp_ud.pop_front());
            check("stream_mode", {bus.buffLRMode, bus.buffUDMode}, 2'b00);
          end
          stream_cnt++;
        end
        if (bus.outValid) begin
          if (exp_res.size() == 0) check("result_unexpected", bus.outData, 32'hFFFF_FFFF);
          else check("outData", bus.outData, exp_res.pop_front());
          beat_cnt++;
        end
        if (bus.done) begin
          if (exp_frm.size() == 0) begin
            check("done_unexpected", 32'd1, 32'd0);
          end else begin
            f = exp_frm.pop_front();
            check("enb_cycles", 32'(stream_cnt), 32'(N));
            check("result_beats", 32'(beat_cnt), 32'(f.beats));
            check("timeout_flag", bus.timeout, 32'(f.to));
            check("done_idle_ctrl", {bus.enb, bus.buffLRMode, bus.buffUDMode}, 3'b000);
          end
        end
        prev_rb = bus.resetBuff;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got running, want finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wrEn   = 1'b0;
    bus.wrData = '0;
    bus.start  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {bus.frameLoaded, bus.busy, bus.enb, bus.resetBuff, bus.outValid,
                            bus.done, bus.timeout, bus.buffLRMode, bus.buffUDMode}, 9'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {bus.busy, bus.frameLoaded}, 2'b00);

    // Directed 4x4 ramp with 0xA0.. results; writes while loaded must be ignored.
    load_frame(1);
    @(negedge clk);
    bus.wrEn = 1'b1; bus.wrData = 8'hEE;
    repeat (2) @(negedge clk);
    bus.wrEn = 1'b0;
    run_frame(5, 1);

    // start before the frame is complete is ignored.
    for (int k = 0; k < N; k++) pix[k] = DW'($urandom);
    write_pix(0, 10);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("early_start_busy", bus.busy, 1'b0);
    @(negedge clk);
    check("early_start_clear", {bus.busy, bus.resetBuff, bus.frameLoaded}, 3'b000);
    write_pix(10, N);
    check("late_loaded", bus.frameLoaded, 1'b1);
    run_frame(0, 0);

    // Drain limit, then complete on the final allowed cycle.
    load_frame(0);
    run_frame(20, 1);
    check("timeout_sticky", bus.timeout, 1'b1);
    load_frame(0);
    run_frame(DMAX - 1, 0);

    // Asynchronous reset in stream cycle 7.
    load_frame(0);
    issue_frame(4, 0);
    begin
      int cyc = 0;
      while (!bus.enb && cyc < 10) begin @(negedge clk); cyc++; end
      check("stream_started", bus.enb, 1'b1);
    end
    repeat (7) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midreset_outputs", {bus.frameLoaded, bus.busy, bus.lRArray, bus.uDArray, bus.enb,
                               bus.buffLRMode, bus.buffUDMode, bus.resetBuff, bus.outValid,
                               bus.outData, bus.done, bus.timeout}, 32'd0);
    check("midreset_frame", bus.frameLoaded, 1'b0);
    $display("reset: asserted in stream cycle 7");
    exp_lr.delete(); exp_ud.delete(); exp_res.delete(); exp_frm.delete();
    @(negedge clk);
    reset = 1'b1;
    load_frame(0);
    run_frame(4, 0);

    for (int i = 0; i < 4; i++) begin
      load_frame(0);
      run_frame(int'($urandom_range(0, 10)), 0);
    end

`ifdef EDGE_SEQ_CHECKSUM_EN
    load_frame(0);
    run_frame(3, 2);
    check("resultSum", bus.resultSum, 16'h02FD);
`endif

    repeat (3) @(negedge clk);
    check("queues_drained", 32'(exp_lr.size() + exp_res.size() + exp_frm.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/edge_stream_sequencer.md
Name: edge_stream_sequencer

Overview:
- Frame-level driver for the all-directions edge detector.
- Buffers one greyscale frame loaded in raster order.
- Replays the frame to the detector as two simultaneous streams: row-major on the left/right input, column-major on the up/down input.
- Then switches the detector buffers to drain mode and forwards the result stream until the detector raises complete.
- Replaces file-driven stimulus in the synthesizable datapath.

Parameters:
- IMG_W, 4, frame width in pixels (>=2)
- IMG_H, 4, frame height in pixels (>=2)
- DATA_W, 8, pixel and result width
- DRAIN_MAX, 256, maximum drain cycles before timeout

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- wrEn  in  1  pixel write strobe, raster order
- wrData  in  DATA_W  pixel written when wrEn=1
- start  in  1  single-cycle pulse; begins stream+drain of loaded frame
- frameLoaded  out  1  high once IMG_W*IMG_H pixels are stored
- busy  out  1  high in any state other than IDLE
- lRArray  out  DATA_W  row-major pixel to detector
- uDArray  out  DATA_W  column-major pixel to detector
- enb  out  1  detector enable
- buffLRMode  out  1  detector L/R buffer drain select
- buffUDMode  out  1  detector U/D buffer drain select
- resetBuff  out  1  detector buffer clear
- complete  in  1  detector drain finished
- detData  in  DATA_W  detector output value
- outValid  out  1  outData valid this cycle
- outData  out  DATA_W  forwarded detector result
- done  out  1  one-cycle pulse at end of frame
- timeout  out  1  sticky: last drain hit DRAIN_MAX; cleared on next accepted start

Behaviour:
- Reset (reset=0, async):
  - All outputs 0; state IDLE.
  - Write pointer 0; frame buffer contents undefined.
- Load:
  - wrEn in IDLE with frameLoaded=0 stores wrData at wrPtr; wrPtr increments.
  - frameLoaded rises the cycle after the IMG_W*IMG_H-th write.
  - wrEn while frameLoaded=1 or busy=1 is ignored; no wrap, no overwrite.
- start:
  - Accepted only in IDLE with frameLoaded=1; otherwise ignored, no state change.
- FSM (all outputs registered):
  - IDLE->CLEAR on accepted start.
  - CLEAR: 1 cycle, resetBuff=1, enb=0; ->STREAM.
  - STREAM: exactly IMG_W*IMG_H cycles, enb=1, buffLRMode=buffUDMode=0.
    - Cycle k: lRArray=pix[k].
    - Cycle k: uDArray=pix[(k mod IMG_H)*IMG_W + (k div IMG_H)].
    - Index counters are separate row/col counters; no divider.
    - First pixel is presented in the same cycle enb first reads 1.
    - After the last cycle ->GAP.
  - GAP: 1 cycle, enb=0, arrays hold last value; ->DRAIN.
  - DRAIN: enb=1, buffLRMode=buffUDMode=1.
    - Each cycle with complete=0: next cycle outValid=1, outData=detData (1-cycle latency).
    - complete=1 sampled ->DONE; no outValid for that sample.
    - Drain cycle counter reaching DRAIN_MAX ->DONE with timeout=1.
  - DONE: 1 cycle, done=1, enb=0, buffModes=0.
    - frameLoaded cleared, wrPtr cleared; ->IDLE.
- Simultaneous events:
  - start and wrEn in the same IDLE cycle: write is ignored (frameLoaded already 1).
  - complete already high on DRAIN entry: zero results, DONE next cycle.
  - complete and the DRAIN_MAX count in the same cycle: complete wins, timeout=0.
- Reset mid-operation: immediate return to IDLE, all outputs 0, frame discarded.

Optional Feature:
- Macro: EDGE_SEQ_CHECKSUM_EN.
- Defined:
  - Extra output port resultSum [15:0].
  - Sum of every forwarded outData, modulo 2^16.
  - Cleared in CLEAR; holds after DONE until the next CLEAR.
- Undefined:
  - Port and adder absent.
  - All other behaviour identical.

Test Plan:
- 4x4 frame, pix[k]=k.
  - Check: lRArray sequence 0..15.
  - Check: uDArray sequence 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15.
  - Check: enb high exactly 16 cycles, preceded by a 1-cycle resetBuff.
- Drain with model detector returning detData=0xA0+n for 5 cycles, then complete=1.
  - Check: 5 outValid beats 0xA0..0xA4.
  - Check: done pulse; buffModes back to 0.
- start before frame fully loaded (10 writes only).
  - Check: ignored; busy=0.
  - Check: 6 more writes, then start, proceeds normally.
- DRAIN_MAX=8 with complete held 0.
  - Check: 8 outValid beats, then timeout=1, done=1.
  - Check: next start clears timeout.
- Assert reset=0 in STREAM cycle 7.
  - Check: all outputs 0 asynchronously; frameLoaded=0.
  - Check: reload plus start gives the full correct sequence.
- EDGE_SEQ_CHECKSUM_EN defined, results 0xFF x 3.
  - Check: resultSum=0x02FD after done.
